// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Feeds a DSP48A1 slice (A0/A1/B0/B1/M/P/OPMODE registered) so that it
//   accumulates N_TERMS unsigned 18x18 products per group. It tracks the
//   slice pipeline and hands the finished sum out on a valid/ready stream.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   s_valid/s_ready      input term handshake
//   s_sample, s_coef     18-bit unsigned operands (slice A / B)
//   dsp_a, dsp_b, dsp_d  slice operand inputs (D tied to 0)
//   dsp_opmode           slice OPMODE (01: P=M, 09: P=P+M)
//   dsp_ce, dsp_rst      slice clock enable (always 1) and reset (high)
//   dsp_p                slice P output
//   m_valid/m_ready      result handshake
//   m_data               48-bit accumulated sum, held until the next capture
module dsp_mac_sequencer #(
    parameter int N_TERMS = 8,
    parameter int DSP_LAT = 4,
    parameter int OP_SKEW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_sample,
    input  logic [17:0] s_coef,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data
);
    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int IW = $clog2(DSP_LAT + 1) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);
    localparam logic [7:0] OP_FIRST = 8'h01;   // X=M, Z=0
    localparam logic [7:0] OP_ACC   = 8'h09;   // X=M, Z=P

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_init_cnt;
    logic [CW-1:0]          r_cnt;
    logic [17:0]            r_a, r_b;
    logic [OP_SKEW:0][7:0]  r_op_pipe;
    logic [DSP_LAT:0]       r_last_pipe;
    logic                   r_m_valid;
    logic [47:0]            r_m_data;

    logic       w_run;
    logic       w_hs;
    logic       w_is_last;
    logic       w_last_inflight;
    logic [7:0] w_tag;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        dsp_rst     = 1'b0;
        case (r_state)
            ST_INIT: begin
                dsp_rst = 1'b1;
                // DSP_LAT+1 flush cycles clear every slice register stage
                if (r_init_cnt == IW'(DSP_LAT)) w_state_nxt = ST_RUN;
            end
            ST_RUN:  w_run = 1'b1;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // ---------------- handshake / backpressure ----------------
    // Only the last term of a group is held back: it may not start until
    // the output buffer is empty and no earlier result is still in flight,
    // so a capture can never overwrite an unread sum.
    assign w_is_last       = (r_cnt == LAST_CNT);
    assign w_last_inflight = |r_last_pipe;
    assign s_ready         = w_run && !(w_is_last && (r_m_valid || w_last_inflight));
    assign w_hs            = s_valid && s_ready;

    // Bubbles still carry the accumulate tag so they add a zero product.
    assign w_tag = !w_run                    ? 8'h00    :
                   (w_hs && r_cnt == '0)     ? OP_FIRST : OP_ACC;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init_cnt  <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op_pipe   <= '0;
            r_last_pipe <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else begin
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;

            r_a <= w_hs ? s_sample : '0;
            r_b <= w_hs ? s_coef   : '0;

            // OPMODE lags its operands by OP_SKEW so it meets the product
            // at the slice post-adder.
            r_op_pipe[0] <= w_tag;
            for (int i = 1; i <= OP_SKEW; i++) r_op_pipe[i] <= r_op_pipe[i-1];

            // Last-term marker follows the term through the slice; when it
            // falls out the end the group's sum is sitting on dsp_p.
            r_last_pipe[0] <= w_hs && w_is_last;
            for (int i = 1; i <= DSP_LAT; i++) r_last_pipe[i] <= r_last_pipe[i-1];

            if (w_hs) r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;

            if (r_last_pipe[DSP_LAT]) begin
                r_m_valid <= 1'b1;
                r_m_data  <= dsp_p;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign dsp_a      = r_a;
    assign dsp_b      = r_b;
    assign dsp_d      = '0;
    assign dsp_ce     = 1'b1;
    assign dsp_opmode = r_op_pipe[OP_SKEW];
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Upstream controller for the DSP48A1 slice. It accepts (sample, coefficient) pairs on a valid/ready stream and drives the slice's A/B/D/OPMODE/CE/reset inputs so the slice computes an N-term multiply-accumulate. It tracks the slice pipeline, captures the finished sum from the slice's P output, and presents it on a valid/ready result stream. Throughout, "the slice" means a DSP48A1 configured with A0/A1/B0/B1/M/P/OPMODE registers enabled, B_input="DIRECT" and CarryInSel="OPMODE5".

## Interface
Parameters:
- N_TERMS, 8: terms per accumulation group; legal range 1..256.
- DSP_LAT, 4: number of slice clock edges from operand presentation to the P register edge.
- OP_SKEW, 2: delay of OPMODE relative to its operands, in cycles.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  input term valid.
- s_ready  out  1  input term accepted when s_valid && s_ready.
- s_sample  in  18  unsigned multiplicand; drives the slice A input.
- s_coef  in  18  unsigned multiplier; drives the slice B input.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_d  out  18  to slice D; constant 0.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_ce  out  1  to all slice CE inputs; constant 1.
- dsp_rst  out  1  active-high; to all slice RST inputs.
- dsp_p  in  48  from slice P.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  48  accumulated sum.

## Operation
State machine:
- INIT: entered on reset.
  - dsp_rst=1 for DSP_LAT+1 cycles to flush the slice; s_ready=0.
  - Then go to RUN.
- RUN: normal operation. The block never re-enters INIT without a reset.

Term counter `cnt`, range 0..N_TERMS-1:
- Increments on each accepted term and wraps to 0 after N_TERMS-1.
- When cnt==0 the term is "first"; when cnt==N_TERMS-1 the term is "last". With N_TERMS=1, every term is both first and last.

Operand and OPMODE issue, every RUN cycle:
- After a handshake, dsp_a/dsp_b register s_sample/s_coef.
- With no handshake (bubble), dsp_a/dsp_b register 0. The bubble contributes 0 to P.
- OPMODE tag registered at the same time as the operands:
  - 8'h01 (X=M, Z=0) for a first term.
  - 8'h09 (X=M, Z=P) otherwise, including bubbles.
- The tag is delayed OP_SKEW cycles before driving dsp_opmode, so it reaches the slice's post-adder together with its product.

Result capture:
- A "last" flag travels with each term through a DSP_LAT+1 stage shift register.
- When the flag emerges: m_data <= dsp_p and m_valid <= 1.
- m_valid clears on m_valid && m_ready. m_data holds its value until the next capture.

Backpressure:
- s_ready = RUN && !(cnt==N_TERMS-1 && (m_valid || last_inflight)).
- Non-last terms are never blocked. The last term waits until the output buffer is empty and no last term is in flight. This guarantees a capture never overwrites an unread result.
- s_ready is computed from registered state only. A same-cycle m_ready does not raise s_ready until the next cycle.

Arithmetic:
- Unsigned 18x18 products give a 36-bit result, zero-extended into a 48-bit add.
- Overflow past 48 bits wraps modulo 2^48 and is not flagged.

## Timing
Reset values (rst_n=0 at an edge):
- s_ready=0, m_valid=0, m_data=0.
- dsp_a=0, dsp_b=0, dsp_d=0, dsp_opmode=0.
- dsp_rst=1, dsp_ce=1.
- cnt=0; all shift registers cleared.

First acceptance:
- s_ready first rises DSP_LAT+1 cycles after the rst_n deassertion edge.

Latency:
- A term accepted in cycle c0 appears on dsp_a/dsp_b in c0+1.
- Its tag appears on dsp_opmode in c0+1+OP_SKEW.
- Its product is in P after the edge ending cycle c0+DSP_LAT.
- m_valid for a last term rises in cycle c0+DSP_LAT+2 (cycle c0+6 with defaults).

Throughput:
- One term per cycle sustained.
- Back-to-back groups are allowed when m_ready=1.

Reset mid-group:
- The partial sum is discarded, cnt returns to 0, and any in-flight last flag is dropped.
- INIT repeats. No m_valid pulse is produced for the interrupted group.

Simultaneous events:
- A capture in the same cycle as an m_valid&&m_ready handshake is impossible by construction.
- An m_ready handshake and a last-term acceptance may coincide only if m_valid was already 0.

## Test plan
- Reset/INIT: hold rst_n=0 for 3 cycles, then release.
  - During reset: dsp_rst=1, s_ready=0, m_valid=0.
  - s_ready rises exactly 5 cycles after release.
- Basic MAC: N_TERMS=4, m_ready=1, terms (1,5),(2,6),(3,7),(4,8) back-to-back.
  - m_data=70; m_valid rises 6 cycles after the 4th acceptance.
  - dsp_opmode sequence is 01,09,09,09.
- Max operands: N_TERMS=4, all terms (0x3FFFF,0x3FFFF).
  - m_data=0x3_FFFE0_0004 (4·(2^18−1)²).
- Bubbles: same terms as Basic MAC with s_valid low for 2 cycles between every term.
  - m_data=70; bubbles add 0.
- Backpressure: two groups (1,1)x4 then (2,2)x4, m_ready=0 until cycle 30.
  - First result 4 held on m_data.
  - s_ready=0 while the second group's last term is offered.
  - After m_ready rises, second result 16 follows; no result is lost or duplicated.
- Reset mid-group: accept 2 of 4 terms, pulse rst_n low, then send (1,1)x4.
  - No stale result appears; first m_data=4.
